// File: rtl/shift_engine.sv
// shift_engine: W-bit parallel-load register with a command-driven 1-bit/cycle
// shifter (SLL, SRL, SRA, ROR). A command of N shifts runs one shift per clock.
// serial_out/serial_out_valid report each shifted-out bit.
// done pulses one cycle after the command's last shift edge.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   load, d_in            parallel load (honoured in IDLE only)
//   cmd_valid, cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_op, cmd_amt       op (00 SLL, 01 SRL, 10 SRA, 11 ROR) and shift count
//   serial_in             fill bit for SLL/SRL, sampled live on every shift
//   q                     register contents
//   busy, done            shift in progress / command-complete pulse
//   serial_out(_valid)    last bit shifted out / one-cycle pulse per shift
//   abort                 only with SHIFT_ENGINE_ABORT_EN defined: ends a running
//                         command after the current edge's shift
//
// Optional feature macro: SHIFT_ENGINE_ABORT_EN
module shift_engine #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = $clog2(W + 1)
) (
`ifdef SHIFT_ENGINE_ABORT_EN
   input  logic          abort,
`endif
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  d_in,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_amt,
   input  logic          serial_in,
   output logic [W-1:0]  q,
   output logic          busy,
   output logic          done,
   output logic          serial_out,
   output logic          serial_out_valid
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_op, w_op_nxt;
   logic [W-1:0]  r_q, w_q_nxt, w_q_shift;
   logic          r_so, w_so_nxt;
   logic          r_sov, w_sov_nxt;
   logic          r_done, w_done_nxt;
   logic          w_bit_out;
   logic          w_abort;

`ifdef SHIFT_ENGINE_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Load has priority over a command offered in the same IDLE cycle
   assign cmd_ready        = (r_state == S_IDLE) && !load;
   assign q                = r_q;
   assign busy             = (r_state == S_SHIFT);
   assign done             = r_done;
   assign serial_out       = r_so;
   assign serial_out_valid = r_sov;

   // One-bit shift of the current register under the latched op
   always_comb begin
      w_q_shift = r_q;
      w_bit_out = r_q[0];
      case (r_op)
         OP_SLL: begin
            w_q_shift = {r_q[W-2:0], serial_in};
            w_bit_out = r_q[W-1];
         end
         OP_SRL:  w_q_shift = {serial_in, r_q[W-1:1]};
         OP_SRA:  w_q_shift = {r_q[W-1], r_q[W-1:1]};
         default: w_q_shift = {r_q[0], r_q[W-1:1]};
      endcase
   end

   // Next-state and output logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      w_q_nxt     = r_q;
      w_so_nxt    = r_so;
      w_sov_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load) begin
               w_q_nxt = d_in;
            end else if (cmd_valid) begin
               if (cmd_amt == '0) begin
                  // Zero-length command completes immediately
                  w_done_nxt = 1'b1;
               end else begin
                  w_op_nxt    = cmd_op;
                  w_cnt_nxt   = cmd_amt;
                  w_state_nxt = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            w_q_nxt   = w_q_shift;
            w_so_nxt  = w_bit_out;
            w_sov_nxt = 1'b1;
            w_cnt_nxt = r_cnt - AW'(1);
            // Abort still takes this edge's shift, then stops
            if (r_cnt == AW'(1) || w_abort) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_SLL;
         r_q     <= '0;
         r_so    <= 1'b0;
         r_sov   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_q     <= w_q_nxt;
         r_so    <= w_so_nxt;
         r_sov   <= w_sov_nxt;
         r_done  <= w_done_nxt;
      end
   end

endmodule
